ecb_frame_sequencer: RTL and testbench
======================================

# ecb_frame_sequencer

Sequences a full image frame, row by row, through the team's keyed per-row XOR cipher, and owns the frame-level control around that datapath. The block sits between the row source (frame buffer or UART receive path) and the row sink (display or transmit path) and exchanges rows with both over valid/ready handshakes. It does the following:
- Latches the key for the whole frame.
- Optionally rotates the key once per row.
- Tags each output row with its index.
- Signals frame completion.

Because the cipher is an involution, the same block both encrypts and decrypts.

## Interface
- BLOCK_SIZE, 32, key width in bits
- HSIZE, 768, row width in bits
- VSIZE, 256, rows per frame (must be ≥ 2)
- clk  in  1  system clock; all logic is on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle frame start; sampled only in IDLE
- key  in  BLOCK_SIZE  frame key; sampled only with an accepted start
- key_rot  in  1  per-row key rotation enable; sampled only with an accepted start
- in_valid  in  1  in_row is valid
- in_ready  out  1  block accepts in_row this cycle
- in_row  in  HSIZE  plaintext or ciphertext row
- out_valid  out  1  out_row, out_idx and out_last are valid
- out_ready  in  1  sink accepts the output this cycle
- out_row  out  HSIZE  transformed row
- out_idx  out  ROW_IDX_W  index of the row (0..VSIZE-1)
- out_last  out  1  out_row is row VSIZE-1
- busy  out  1  state is not IDLE
- done  out  1  one-cycle pulse at frame completion

## Operation
- **ROW_IDX_W:** equals clog2(VSIZE).
- **States:** IDLE, RUN, DRAIN.
- **IDLE:**
  - in_ready = 0.
  - start = 1 latches key into key_q and key_rot into rot_q, clears row_cnt, and moves to RUN.
- **Input acceptance (RUN):** a row is accepted when in_valid && in_ready. The register stage is ready when in_ready = !out_valid || out_ready.
- **On an accepted row:**
  - out_row[i] <= in_row[i] ^ ekey[i % BLOCK_SIZE] for every i in 0..HSIZE-1. HSIZE need not be a multiple of BLOCK_SIZE.
  - ekey = rot_q ? rotl(key_q, row_cnt % BLOCK_SIZE) : key_q.
  - out_idx <= row_cnt; out_last <= (row_cnt == VSIZE-1); out_valid <= 1; row_cnt++.
- **End of input:** accepting row VSIZE-1 moves the block to DRAIN, and in_ready goes to 0 from the next cycle.
- **DRAIN:**
  - No input is accepted.
  - When the out_last row handshakes (out_valid && out_ready), the block clears out_valid, returns to IDLE and asserts done for exactly the next cycle.
- **Output clearing:** out_valid clears on an output handshake with no simultaneous input accept.
- **Ignored inputs:**
  - start while busy is ignored; key and key_rot do not change mid-frame.
  - in_valid outside RUN is ignored.
- **Reset:**
  - rst overrides everything: state goes to IDLE, row_cnt to 0, and in-flight data is discarded.
  - No done pulse is generated for an aborted frame.
- **Reset values:** in_ready=0, out_valid=0, out_row=0, out_idx=0, out_last=0, busy=0, done=0, key_q=0, rot_q=0.

## Timing
- **Latency:** 1 cycle from input handshake to out_valid.
- **Throughput:** 1 row per cycle when out_ready is held at 1. A frame takes VSIZE+1 cycles from the first accept to the done pulse.
- **First accept:** the earliest input accept is the cycle after start.
- **Backpressure:**
  - While out_valid && !out_ready, out_row, out_idx and out_last hold stable and in_ready = 0.
  - Input and output handshakes in the same cycle replace the register contents, so there is no bubble.
- **done:** registered; high for one cycle, coincident with the first IDLE cycle. A start in that cycle is accepted.
- **busy:** high from the cycle after the accepted start through the last DRAIN cycle.

## Structure
- **Package ecb_seq_pkg:**
  - state enum {IDLE, RUN, DRAIN}.
  - function rotl(key, amt) with width BLOCK_SIZE.
  - ROW_IDX_W derivation helper.
- **Sub-module ecb_row_xor:** combinational; parameters BLOCK_SIZE and HSIZE; inputs row and ekey, output row XOR the repeated ekey. It is instantiated once, ahead of the output register.
- **Top level:** holds the FSM, row_cnt, key_q/rot_q, the output register and the done flop.

## Test plan
- **Basic frame:** defaults, key=32'hA5A5_0F0F, key_rot=0, all-zero rows, out_ready=1 → each out_row is 24 copies of A5A50F0F. out_idx counts 0..255, out_last is high only at 255, and done pulses once, 257 cycles after the first accept.
- **Key rotation:** key=32'h0000_0001, key_rot=1, zero rows → row 2 low word is 32'h0000_0004, row 31 is 32'h8000_0000, and row 32 returns to 32'h0000_0001.
- **Backpressure:** toggle out_ready 1,0,0,1 with in_valid held at 1 → out_row/out_idx hold through the stall, in_ready=0 while stalled, and no row is dropped or duplicated.
- **Round trip:** random frame encrypted and fed back with the same key and key_rot=1 → output equals the original frame bit-for-bit.
- **Start ignored while busy:** start with key=32'h1111_1111 pulsed mid-frame → ignored; the remaining rows still use the original key and busy stays 1.
- **Reset mid-frame:** rst at row 100 → the next cycle shows all outputs at reset values with no done pulse. A new start then produces out_idx 0.

Source files
------------

// File: rtl/ecb_seq_pkg.sv
// Shared types and helpers for the frame sequencer: FSM states, the key
// rotation function and the row-index width derivation.
package ecb_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Widest key the rotation helper supports; callers truncate the result.
    localparam int MAX_BLOCK = 64;

    function automatic int row_idx_w(input int vsize);
        return (vsize < 2) ? 1 : $clog2(vsize);
    endfunction

    // Rotate the low 'width' bits of key left by amt (amt < width).
    function automatic logic [MAX_BLOCK-1:0] rotl(input logic [MAX_BLOCK-1:0] key,
                                                  input int amt,
                                                  input int width);
        logic [MAX_BLOCK-1:0] r;
        int j;
        r = '0;
        for (int i = 0; i < MAX_BLOCK; i++) begin
            if (i < width) begin
                j = i + amt;
                if (j >= width) j = j - width;
                r[j] = key[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ecb_row_xor.sv
// Combinational row cipher: XORs a row with the key repeated across its width.
module ecb_row_xor #(
    parameter int BLOCK_SIZE = 32,
    parameter int HSIZE      = 768
) (
    input  logic [HSIZE-1:0]      i_row,
    input  logic [BLOCK_SIZE-1:0] i_ekey,
    output logic [HSIZE-1:0]      o_row
);

    // The last key copy is simply cut short when HSIZE is not a key multiple.
    for (genvar i = 0; i < HSIZE; i++) begin : g_bit
        assign o_row[i] = i_row[i] ^ i_ekey[i % BLOCK_SIZE];
    end

endmodule

// File: rtl/ecb_frame_sequencer.sv
// Frame-level sequencer around the keyed row XOR: latches the key per frame,
// optionally rotates it per row, tags rows with their index and flags done.
//
// state | meaning
// IDLE  | waiting for start; no input accepted
// RUN   | accepting rows through the single output register stage
// DRAIN | last row accepted; waiting for it to leave the output register
module ecb_frame_sequencer
    import ecb_seq_pkg::*;
#(
    parameter  int BLOCK_SIZE = 32,
    parameter  int HSIZE      = 768,
    parameter  int VSIZE      = 256,
    localparam int ROW_IDX_W  = row_idx_w(VSIZE)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [BLOCK_SIZE-1:0] i_key,
    input  logic                  i_key_rot,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    input  logic [HSIZE-1:0]      i_in_row,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [HSIZE-1:0]      o_out_row,
    output logic [ROW_IDX_W-1:0]  o_out_idx,
    output logic                  o_out_last,
    output logic                  o_busy,
    output logic                  o_done
);

    state_t                r_state;
    logic [BLOCK_SIZE-1:0] r_key;
    logic                  r_rot;
    logic [ROW_IDX_W-1:0]  r_row_cnt;
    logic                  r_out_valid;
    logic [HSIZE-1:0]      r_out_row;
    logic [ROW_IDX_W-1:0]  r_out_idx;
    logic                  r_out_last;
    logic                  r_done;

    logic                  w_in_ready;
    logic                  w_in_fire;
    logic                  w_out_fire;
    logic                  w_last_in;
    int                    w_rot_amt;
    logic [BLOCK_SIZE-1:0] w_ekey;
    logic [HSIZE-1:0]      w_xor_row;

    always_comb begin
        w_rot_amt = int'(32'(r_row_cnt) % BLOCK_SIZE);
        w_ekey    = r_rot ? BLOCK_SIZE'(rotl(MAX_BLOCK'(r_key), w_rot_amt, BLOCK_SIZE))
                          : r_key;
    end

    ecb_row_xor #(
        .BLOCK_SIZE (BLOCK_SIZE),
        .HSIZE      (HSIZE)
    ) u_row_xor (
        .i_row  (i_in_row),
        .i_ekey (w_ekey),
        .o_row  (w_xor_row)
    );

    // Accept when the output register is empty or being emptied this cycle.
    assign w_in_ready = (r_state == RUN) && (!r_out_valid || i_out_ready);
    assign w_in_fire  = i_in_valid && w_in_ready;
    assign w_out_fire = r_out_valid && i_out_ready;
    assign w_last_in  = (r_row_cnt == ROW_IDX_W'(VSIZE - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_key       <= '0;
            r_rot       <= 1'b0;
            r_row_cnt   <= '0;
            r_out_valid <= 1'b0;
            r_out_row   <= '0;
            r_out_idx   <= '0;
            r_out_last  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_key     <= i_key;
                        r_rot     <= i_key_rot;
                        r_row_cnt <= '0;
                        r_state   <= RUN;
                    end
                end
                RUN: begin
                    if (w_in_fire) begin
                        r_out_row   <= w_xor_row;
                        r_out_idx   <= r_row_cnt;
                        r_out_last  <= w_last_in;
                        r_out_valid <= 1'b1;
                        r_row_cnt   <= r_row_cnt + 1'b1;
                        if (w_last_in) r_state <= DRAIN;
                    end else if (w_out_fire) begin
                        r_out_valid <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (w_out_fire) begin
                        r_out_valid <= 1'b0;
                        if (r_out_last) begin
                            r_state <= IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_in_ready  = w_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_out_row   = r_out_row;
    assign o_out_idx   = r_out_idx;
    assign o_out_last  = r_out_last;
    assign o_busy      = (r_state != IDLE);
    assign o_done      = r_done;

endmodule

// File: tb/tb_ecb_frame_sequencer.sv
// Directed bench for ecb_frame_sequencer: table of frame vectors with
// hand-computed row words, plus round-trip and mid-frame reset sequences.
module tb_ecb_frame_sequencer;

    localparam int BS = 32;
    localparam int HS = 768;
    localparam int VS = 256;
    localparam int IW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [BS-1:0] key = '0;
    logic          key_rot = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [HS-1:0] in_row = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [HS-1:0] out_row;
    logic [IW-1:0] out_idx;
    logic          out_last;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    ecb_frame_sequencer #(
        .BLOCK_SIZE (BS),
        .HSIZE      (HS),
        .VSIZE      (VS)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_key       (key),
        .i_key_rot   (key_rot),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_in_row    (in_row),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_row   (out_row),
        .o_out_idx   (out_idx),
        .o_out_last  (out_last),
        .o_busy      (busy),
        .o_done      (done)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [HS-1:0] src  [VS];
    logic [HS-1:0] cap  [VS];
    logic [HS-1:0] orig [VS];

    typedef struct {
        logic [31:0] key;
        bit          rot;
        bit          stall;
        bit          mid;
        int          idx;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [HS-1:0] act, input logic [HS-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [HS-1:0] model_row(input logic [31:0] k, input bit rot,
                                                input int idx, input logic [HS-1:0] d);
        logic [63:0] t;
        logic [31:0] ek;
        t  = {k, k} << (rot ? (idx % 32) : 0);
        ek = t[63:32];
        return d ^ {24{ek}};
    endfunction

    task automatic run_frame(input logic [31:0] k, input bit rot, input bit stall,
                             input bit mid_start, input string tag);
        int            kk, nout, cyc, first_acc, done_cyc;
        bit            held;
        logic [HS-1:0] h_row;
        logic [IW-1:0] h_idx;
        logic          h_last;
        start = 1'b1; key = k; key_rot = rot;
        @(posedge clk); #1;
        start = 1'b0;
        kk = 0; nout = 0; cyc = 0; first_acc = -1; done_cyc = -1; held = 1'b0;
        h_row = '0; h_idx = '0; h_last = 1'b0;
        while (done_cyc < 0 && cyc < 3000) begin
            start     = mid_start && (cyc == 50);
            key       = start ? 32'h1111_1111 : k;
            key_rot   = start ? ~rot : rot;
            in_valid  = (kk < VS);
            in_row    = (kk < VS) ? src[kk] : '0;
            out_ready = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            @(negedge clk);
            if (held) begin
                chk($sformatf("%s_hold_row_c%0d", tag, cyc), out_row, h_row);
                chk($sformatf("%s_hold_idx_c%0d", tag, cyc), HS'(out_idx), HS'(h_idx));
                chk($sformatf("%s_hold_last_c%0d", tag, cyc), HS'(out_last), HS'(h_last));
            end
            held = out_valid && !out_ready;
            if (held) begin
                h_row = out_row; h_idx = out_idx; h_last = out_last;
                chk($sformatf("%s_stall_in_ready_c%0d", tag, cyc), HS'(in_ready), HS'(0));
            end
            if (done) begin
                done_cyc = cyc;
                chk($sformatf("%s_busy_at_done", tag), HS'(busy), HS'(0));
            end else begin
                chk($sformatf("%s_busy_c%0d", tag, cyc), HS'(busy), HS'(1));
            end
            if (out_valid && out_ready) begin
                if (nout < VS) begin
                    chk($sformatf("%s_idx%0d", tag, nout), HS'(out_idx), HS'(nout));
                    chk($sformatf("%s_last%0d", tag, nout), HS'(out_last), HS'(nout == VS - 1));
                    cap[nout] = out_row;
                end
                nout++;
            end
            if (in_valid && in_ready) begin
                if (first_acc < 0) first_acc = cyc;
                kk++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0; start = 1'b0; key = k; key_rot = rot;
        chk($sformatf("%s_done_seen", tag), HS'(done_cyc >= 0), HS'(1));
        chk($sformatf("%s_row_count", tag), HS'(nout), HS'(VS));
        chk($sformatf("%s_first_acc", tag), HS'(first_acc), HS'(0));
        if (!stall)
            chk($sformatf("%s_done_latency", tag), HS'(done_cyc - first_acc), HS'(VS + 1));
        @(negedge clk);
        chk($sformatf("%s_done_one_cycle", tag), HS'(done), HS'(0));
        for (int r = 0; r < VS; r++)
            chk($sformatf("%s_row%0d", tag, r), cap[r], model_row(k, rot, r, src[r]));
        @(posedge clk); #1;
    endtask

    task automatic reset_mid();
        int kk, cyc;
        kk = 0; cyc = 0;
        start = 1'b1; key = 32'hA5A5_0F0F; key_rot = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b1; out_ready = 1'b1; in_row = '0;
        while (kk < 100 && cyc < 500) begin
            @(negedge clk);
            if (in_valid && in_ready) kk++;
            @(posedge clk); #1;
            cyc++;
        end
        chk("rst_rows_reached", HS'(kk), HS'(100));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", HS'(in_ready), HS'(0));
        chk("rst_out_valid", HS'(out_valid), HS'(0));
        chk("rst_out_row", out_row, HS'(0));
        chk("rst_out_idx", HS'(out_idx), HS'(0));
        chk("rst_out_last", HS'(out_last), HS'(0));
        chk("rst_busy", HS'(busy), HS'(0));
        chk("rst_done", HS'(done), HS'(0));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("rst_no_done_%0d", i), HS'(done), HS'(0));
            chk($sformatf("rst_no_ready_%0d", i), HS'(in_ready), HS'(0));
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        vecs[0] = '{32'hA5A5_0F0F, 1'b0, 1'b0, 1'b0, 0,   32'hA5A5_0F0F};
        vecs[1] = '{32'hA5A5_0F0F, 1'b0, 1'b0, 1'b0, 255, 32'hA5A5_0F0F};
        vecs[2] = '{32'h0000_0001, 1'b1, 1'b0, 1'b0, 2,   32'h0000_0004};
        vecs[3] = '{32'h0000_0001, 1'b1, 1'b0, 1'b0, 31,  32'h8000_0000};
        vecs[4] = '{32'h0000_0001, 1'b1, 1'b0, 1'b0, 32,  32'h0000_0001};
        vecs[5] = '{32'h0000_0001, 1'b1, 1'b1, 1'b0, 5,   32'h0000_0020};
        vecs[6] = '{32'hA5A5_0F0F, 1'b0, 1'b0, 1'b1, 200, 32'hA5A5_0F0F};
        vecs[7] = '{32'h8000_0001, 1'b1, 1'b0, 1'b0, 1,   32'h0000_0003};
        vecs[8] = '{32'hF000_0000, 1'b1, 1'b1, 1'b1, 4,   32'h0000_000F};

        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_in_ready", HS'(in_ready), HS'(0));
        chk("reset_out_valid", HS'(out_valid), HS'(0));
        chk("reset_out_row", out_row, HS'(0));
        chk("reset_out_idx", HS'(out_idx), HS'(0));
        chk("reset_out_last", HS'(out_last), HS'(0));
        chk("reset_busy", HS'(busy), HS'(0));
        chk("reset_done", HS'(done), HS'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        for (int v = 0; v < 9; v++) begin
            for (int r = 0; r < VS; r++) src[r] = '0;
            run_frame(vecs[v].key, vecs[v].rot, vecs[v].stall, vecs[v].mid, $sformatf("v%0d", v));
            chk($sformatf("vec%0d_word", v), cap[vecs[v].idx], {24{vecs[v].exp_lo}});
        end

        for (int r = 0; r < VS; r++) begin
            for (int w = 0; w < 24; w++) src[r][w*32 +: 32] = $urandom;
            orig[r] = src[r];
        end
        run_frame(32'h3C5A_9E17, 1'b1, 1'b0, 1'b0, "enc");
        for (int r = 0; r < VS; r++) src[r] = cap[r];
        run_frame(32'h3C5A_9E17, 1'b1, 1'b1, 1'b0, "dec");
        for (int r = 0; r < VS; r++)
            chk($sformatf("roundtrip_row%0d", r), cap[r], orig[r]);

        reset_mid();
        for (int r = 0; r < VS; r++) src[r] = '0;
        run_frame(32'hA5A5_0F0F, 1'b0, 1'b0, 1'b0, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
